// File: rtl/intersection_ctrl.sv
// -----------------------------------------------------------------------------
// intersection_ctrl
//
// Scheduler for a two-road intersection (main road, side road) with a
// pedestrian crossing. The main road rests on green. After its minimum green
// time the controller yields to a pending pedestrian request (first) or to
// the side road. Every phase is timed in ticks from a clock prescaler.
//
// Optional build macro: NIGHT_FLASH_EN
//   When defined, the input night_mode is added, along with a FLASH state
//   (phase 7) in which both yellow lamps blink.
//
// Parameters
//   TICK_DIV    clock cycles per tick (1 = every cycle is a tick)
//   MAIN_GREEN  minimum main green, ticks
//   YELLOW      yellow time for either head, ticks
//   ALL_RED     all-red clearance, ticks
//   SIDE_GREEN  side green, ticks
//   PED_WALK    walk time, ticks
//   Durations are 8-bit values. A zero duration is treated as 1.
//
// Ports
//   clock       in   system clock
//   reset_n     in   asynchronous active-low reset
//   side_req    in   side-road vehicle sensor, level
//   ped_req     in   pedestrian button, sampled every clock
//   night_mode  in   night flashing request (NIGHT_FLASH_EN builds only)
//   M_main      out  main red
//   K_main      out  main yellow
//   H_main      out  main green
//   M_side      out  side red
//   K_side      out  side yellow
//   H_side      out  side green
//   walk        out  pedestrian walk lamp
//   phase       out  current state encoding (state register, debug view)
//   sec_left    out  remaining ticks in the current state
//
// There are no valid/ready handshakes in this block. The request inputs are
// plain levels, sampled on every rising clock edge.
// -----------------------------------------------------------------------------
module intersection_ctrl #(
  parameter int unsigned TICK_DIV   = 1,
  parameter int unsigned MAIN_GREEN = 96,
  parameter int unsigned YELLOW     = 4,
  parameter int unsigned ALL_RED    = 1,
  parameter int unsigned SIDE_GREEN = 20,
  parameter int unsigned PED_WALK   = 10
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       side_req,
  input  logic       ped_req,
`ifdef NIGHT_FLASH_EN
  input  logic       night_mode,
`endif
  output logic       M_main,
  output logic       K_main,
  output logic       H_main,
  output logic       M_side,
  output logic       K_side,
  output logic       H_side,
  output logic       walk,
  output logic [2:0] phase,
  output logic [7:0] sec_left
);

  // ---------------------------------------------------------------------------
  // State encoding. The encoding is visible directly on phase.
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_MAIN_GRN = 3'd0,
    S_MAIN_YEL = 3'd1,
    S_ALL_RED1 = 3'd2,
    S_SIDE_GRN = 3'd3,
    S_SIDE_YEL = 3'd4,
    S_ALL_RED2 = 3'd5,
`ifdef NIGHT_FLASH_EN
    S_PED      = 3'd6,
    S_FLASH    = 3'd7
`else
    S_PED      = 3'd6
`endif
  } state_e;

  // ---------------------------------------------------------------------------
  // Phase durations. Each is truncated to 8 bits, and zero is lifted to 1, so
  // that every timed state lasts at least one tick.
  // ---------------------------------------------------------------------------
  localparam logic [7:0] DUR_MAIN = (MAIN_GREEN == 0) ? 8'd1 : MAIN_GREEN[7:0];
  localparam logic [7:0] DUR_YEL  = (YELLOW     == 0) ? 8'd1 : YELLOW[7:0];
  localparam logic [7:0] DUR_RED  = (ALL_RED    == 0) ? 8'd1 : ALL_RED[7:0];
  localparam logic [7:0] DUR_SIDE = (SIDE_GREEN == 0) ? 8'd1 : SIDE_GREEN[7:0];
  localparam logic [7:0] DUR_PED  = (PED_WALK   == 0) ? 8'd1 : PED_WALK[7:0];

  // ---------------------------------------------------------------------------
  // Prescaler. A divider of 0 behaves like 1. The counter is at least one bit
  // wide, so a divider of 1 simply holds it at 0 with tick always high.
  // ---------------------------------------------------------------------------
  localparam int unsigned TDIV = (TICK_DIV == 0) ? 1 : TICK_DIV;
  localparam int unsigned PW   = (TDIV > 1) ? $clog2(TDIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TDIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  assign tick  = (pre_q == PRE_MAX);
  assign pre_d = tick ? '0 : pre_q + PW'(1);

  // ---------------------------------------------------------------------------
  // State, timer and pedestrian latch registers
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       ped_pend_q, ped_pend_d;
`ifdef NIGHT_FLASH_EN
  logic       flash_q, flash_d;
`endif

  // Timer value loaded on entry to each state. FLASH has no countdown and
  // shows 0.
  function automatic logic [7:0] dur_of(state_e s);
    logic [7:0] d;
    d = DUR_MAIN;
    case (s)
      S_MAIN_GRN: d = DUR_MAIN;
      S_MAIN_YEL: d = DUR_YEL;
      S_ALL_RED1: d = DUR_RED;
      S_SIDE_GRN: d = DUR_SIDE;
      S_SIDE_YEL: d = DUR_YEL;
      S_ALL_RED2: d = DUR_RED;
      S_PED:      d = DUR_PED;
`ifdef NIGHT_FLASH_EN
      S_FLASH:    d = 8'd0;
`endif
      default:    d = DUR_MAIN;
    endcase
    return d;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_MAIN_GRN;
      timer_q    <= DUR_MAIN;
      pre_q      <= '0;
      ped_pend_q <= 1'b0;
`ifdef NIGHT_FLASH_EN
      flash_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pre_q      <= pre_d;
      ped_pend_q <= ped_pend_d;
`ifdef NIGHT_FLASH_EN
      flash_q    <= flash_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. All transitions happen on tick cycles only. A timed
  // state exits on the tick where the timer reads 1, so a duration of N spans
  // exactly N ticks. The comparison is <= 1 so that a timer that has
  // saturated at 0 still lets the state exit.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
`ifdef NIGHT_FLASH_EN
    flash_d = flash_q;
`endif

    if (tick) begin
      timer_d = (timer_q != 8'd0) ? timer_q - 8'd1 : 8'd0;

      case (state_q)
        S_MAIN_GRN: begin
          // Main green rests at timer 0 until someone asks for the crossing.
`ifdef NIGHT_FLASH_EN
          if (night_mode && (timer_q == 8'd0)) begin
            state_d = S_FLASH;
          end else
`endif
          if ((timer_q <= 8'd1) && (side_req || ped_pend_q)) begin
            state_d = S_MAIN_YEL;
          end
        end
        S_MAIN_YEL: begin
          if (timer_q <= 8'd1) state_d = S_ALL_RED1;
        end
        S_ALL_RED1: begin
          // Pedestrians take priority over the side road.
          if (timer_q <= 8'd1) state_d = ped_pend_q ? S_PED : S_SIDE_GRN;
        end
        S_SIDE_GRN: begin
          // Fixed length, regardless of whether side_req is still high.
          if (timer_q <= 8'd1) state_d = S_SIDE_YEL;
        end
        S_SIDE_YEL: begin
          if (timer_q <= 8'd1) state_d = S_ALL_RED2;
        end
        S_ALL_RED2: begin
`ifdef NIGHT_FLASH_EN
          if (night_mode) begin
            state_d = S_FLASH;
          end else
`endif
          if (timer_q <= 8'd1) begin
            state_d = S_MAIN_GRN;
          end
        end
        S_PED: begin
          if (timer_q <= 8'd1) state_d = S_ALL_RED2;
        end
`ifdef NIGHT_FLASH_EN
        S_FLASH: begin
          if (!night_mode) begin
            state_d = S_ALL_RED2;
          end else begin
            flash_d = ~flash_q;
          end
        end
`endif
        default: state_d = S_MAIN_GRN;
      endcase

      if (state_d != state_q) begin
        timer_d = dur_of(state_d);
`ifdef NIGHT_FLASH_EN
        // Blinking starts with the lamps lit.
        flash_d = 1'b1;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pedestrian latch. Presses are ignored while the walk phase runs. A press
  // on the edge that enters PED is dropped, because that walk phase already
  // serves it.
  // ---------------------------------------------------------------------------
  always_comb begin
    ped_pend_d = ped_pend_q;
    if ((state_d == S_PED) && (state_q != S_PED)) begin
      ped_pend_d = 1'b0;
    end else if ((state_q != S_PED) && ped_req) begin
      ped_pend_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Lamp decode from the registered state. Exactly one lamp per head is lit,
  // except in FLASH, where only the blinking yellows can be on.
  // ---------------------------------------------------------------------------
  always_comb begin
    M_main   = 1'b1;
    K_main   = 1'b0;
    H_main   = 1'b0;
    M_side   = 1'b1;
    K_side   = 1'b0;
    H_side   = 1'b0;
    walk     = 1'b0;
    case (state_q)
      S_MAIN_GRN: begin
        M_main = 1'b0;
        H_main = 1'b1;
      end
      S_MAIN_YEL: begin
        M_main = 1'b0;
        K_main = 1'b1;
      end
      S_SIDE_GRN: begin
        M_side = 1'b0;
        H_side = 1'b1;
      end
      S_SIDE_YEL: begin
        M_side = 1'b0;
        K_side = 1'b1;
      end
      S_PED: begin
        walk = 1'b1;
      end
`ifdef NIGHT_FLASH_EN
      S_FLASH: begin
        M_main = 1'b0;
        M_side = 1'b0;
        K_main = flash_q;
        K_side = flash_q;
      end
`endif
      default: begin
        // ALL_RED1 / ALL_RED2: both heads red
      end
    endcase
  end

  assign phase    = state_q;
  assign sec_left = timer_q;

endmodule

// File: tb/tb_intersection_ctrl.sv
// -----------------------------------------------------------------------------
// tb_intersection_ctrl
//
// Directed bench for intersection_ctrl. dut_a uses the default parameters
// (TICK_DIV=1). dut_b uses TICK_DIV=4 and is held in reset until its own
// test runs. Each test pushes its hand-derived phase timeline into exp_q as
// per-cycle words {phase, lamps, sec_left}. The bench then steps the clock,
// comparing one popped word per cycle.
// Lamp order: {M_main, K_main, H_main, M_side, K_side, H_side, walk}.
// -----------------------------------------------------------------------------
module tb_intersection_ctrl;

  localparam int W = 18;

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n  = 1'b0;
  logic side_req = 1'b0;
  logic ped_req  = 1'b0;
  logic reset_b_n  = 1'b0;
  logic side_req_b = 1'b0;
  logic ped_req_b  = 1'b0;

  logic       a_m_main, a_k_main, a_h_main, a_m_side, a_k_side, a_h_side, a_walk;
  logic [2:0] a_phase;
  logic [7:0] a_sec;
  logic       b_m_main, b_k_main, b_h_main, b_m_side, b_k_side, b_h_side, b_walk;
  logic [2:0] b_phase;
  logic [7:0] b_sec;

  intersection_ctrl dut_a (
    .clock    (clock),
    .reset_n  (reset_n),
    .side_req (side_req),
    .ped_req  (ped_req),
`ifdef NIGHT_FLASH_EN
    .night_mode (1'b0),
`endif
    .M_main   (a_m_main),
    .K_main   (a_k_main),
    .H_main   (a_h_main),
    .M_side   (a_m_side),
    .K_side   (a_k_side),
    .H_side   (a_h_side),
    .walk     (a_walk),
    .phase    (a_phase),
    .sec_left (a_sec)
  );

  intersection_ctrl #(.TICK_DIV(4)) dut_b (
    .clock    (clock),
    .reset_n  (reset_b_n),
    .side_req (side_req_b),
    .ped_req  (ped_req_b),
`ifdef NIGHT_FLASH_EN
    .night_mode (1'b0),
`endif
    .M_main   (b_m_main),
    .K_main   (b_k_main),
    .H_main   (b_h_main),
    .M_side   (b_m_side),
    .K_side   (b_k_side),
    .H_side   (b_h_side),
    .walk     (b_walk),
    .phase    (b_phase),
    .sec_left (b_sec)
  );

  logic [W-1:0] obs_a, obs_b;
  assign obs_a = {a_phase, a_m_main, a_k_main, a_h_main, a_m_side, a_k_side, a_h_side, a_walk, a_sec};
  assign obs_b = {b_phase, b_m_main, b_k_main, b_h_main, b_m_side, b_k_side, b_h_side, b_walk, b_sec};

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;
  logic         sel_b  = 1'b0;

  localparam logic [2:0] P_MG = 3'd0, P_MY = 3'd1, P_R1 = 3'd2, P_SG = 3'd3,
                         P_SY = 3'd4, P_R2 = 3'd5, P_PED = 3'd6;

  function automatic logic [6:0] lamps_for(logic [2:0] ph);
    case (ph)
      P_MG:    return 7'b0011000;
      P_MY:    return 7'b0101000;
      P_SG:    return 7'b1000010;
      P_SY:    return 7'b1000100;
      P_PED:   return 7'b1001001;
      default: return 7'b1001000;
    endcase
  endfunction

  localparam logic [W-1:0] RST_WORD = {3'd0, 7'b0011000, 8'd96};

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got phase=%0d lamps=%b sec=%0d, expected phase=%0d lamps=%b sec=%0d",
               tag, obs[17:15], obs[14:8], obs[7:0], exp[17:15], exp[14:8], exp[7:0]);
    end
  endtask

  // Queue n cycles of phase ph whose timer starts at sec0 and drops once every
  // tdiv cycles, saturating at 0.
  task automatic push_seg(input logic [2:0] ph, input int n, input int sec0, input int tdiv);
    int s;
    for (int i = 0; i < n; i++) begin
      s = sec0 - (i / tdiv);
      if (s < 0) s = 0;
      exp_q.push_back({ph, lamps_for(ph), 8'(s)});
    end
  endtask

  // Compare the current cycle and advance one clock, n times. Inputs changed
  // between calls reach the DUT on the following rising edge.
  task automatic run(input string tname, input int n);
    logic [W-1:0] e;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      check($sformatf("%s c%0d", tname, cyc), sel_b ? obs_b : obs_a, e);
      @(negedge clock);
      cyc++;
    end
  endtask

  // Put dut_a into reset, check the reset outputs, and leave it in reset at a
  // falling edge so that the caller can set inputs and release it.
  task automatic hold_reset_a(input string tname);
    @(negedge clock);
    reset_n  = 1'b0;
    side_req = 1'b0;
    ped_req  = 1'b0;
    sel_b    = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clock);
    check({tname, " in reset"}, obs_a, RST_WORD);
  endtask

  task automatic release_a();
    reset_n = 1'b1;
    cyc     = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  initial begin
    // 1: no requests; main green rests, timer counts to 0 and holds
    hold_reset_a("t1");
    release_a();
    push_seg(P_MG, 200, 96, 1);
    run("t1", 200);

    // 2: side road held high from reset
    hold_reset_a("t2");
    side_req = 1'b1;
    release_a();
    push_seg(P_MG, 96, 96, 1);
    push_seg(P_MY, 4, 4, 1);
    push_seg(P_R1, 1, 1, 1);
    push_seg(P_SG, 20, 20, 1);
    push_seg(P_SY, 4, 4, 1);
    push_seg(P_R2, 1, 1, 1);
    push_seg(P_MG, 10, 96, 1);
    run("t2", 136);

    // 3: one pedestrian press at cycle 10; latch clears, main green holds after
    hold_reset_a("t3");
    release_a();
    push_seg(P_MG, 96, 96, 1);
    push_seg(P_MY, 4, 4, 1);
    push_seg(P_R1, 1, 1, 1);
    push_seg(P_PED, 10, 10, 1);
    push_seg(P_R2, 1, 1, 1);
    push_seg(P_MG, 110, 96, 1);
    run("t3", 10);
    ped_req = 1'b1;
    run("t3", 1);
    ped_req = 1'b0;
    run("t3", 211);

    // 4: pedestrian and side together at cycle 5; walk first, side after next minimum
    hold_reset_a("t4");
    release_a();
    push_seg(P_MG, 96, 96, 1);
    push_seg(P_MY, 4, 4, 1);
    push_seg(P_R1, 1, 1, 1);
    push_seg(P_PED, 10, 10, 1);
    push_seg(P_R2, 1, 1, 1);
    push_seg(P_MG, 96, 96, 1);
    push_seg(P_MY, 4, 4, 1);
    push_seg(P_R1, 1, 1, 1);
    push_seg(P_SG, 20, 20, 1);
    push_seg(P_SY, 4, 4, 1);
    push_seg(P_R2, 1, 1, 1);
    push_seg(P_MG, 5, 96, 1);
    run("t4", 5);
    ped_req  = 1'b1;
    side_req = 1'b1;
    run("t4", 1);
    ped_req  = 1'b0;
    run("t4", 237);

    // 5a: presses on the PED-entry edge (cycle 100) and inside PED (105) are dropped
    hold_reset_a("t5a");
    release_a();
    push_seg(P_MG, 96, 96, 1);
    push_seg(P_MY, 4, 4, 1);
    push_seg(P_R1, 1, 1, 1);
    push_seg(P_PED, 10, 10, 1);
    push_seg(P_R2, 1, 1, 1);
    push_seg(P_MG, 110, 96, 1);
    run("t5a", 10);
    ped_req = 1'b1;
    run("t5a", 1);
    ped_req = 1'b0;
    run("t5a", 89);
    ped_req = 1'b1;
    run("t5a", 1);
    ped_req = 1'b0;
    run("t5a", 4);
    ped_req = 1'b1;
    run("t5a", 1);
    ped_req = 1'b0;
    run("t5a", 116);

    // 5b: asynchronous reset in the middle of side green
    hold_reset_a("t5b");
    side_req = 1'b1;
    release_a();
    push_seg(P_MG, 96, 96, 1);
    push_seg(P_MY, 4, 4, 1);
    push_seg(P_R1, 1, 1, 1);
    push_seg(P_SG, 4, 20, 1);
    run("t5b", 105);
    check("t5b pre-reset side green", obs_a, {P_SG, lamps_for(P_SG), 8'd16});
    #2;
    reset_n = 1'b0;
    #1;
    check("t5b async reset", obs_a, RST_WORD);
    @(negedge clock);
    release_a();
    push_seg(P_MG, 20, 96, 1);
    run("t5b after", 20);

    // 6: TICK_DIV=4, every phase four times longer
    @(negedge clock);
    reset_n = 1'b0;
    sel_b   = 1'b1;
    exp_q.delete();
    check("t6 in reset", obs_b, RST_WORD);
    side_req_b = 1'b1;
    reset_b_n  = 1'b1;
    cyc        = 0;
    push_seg(P_MG, 384, 96, 4);
    push_seg(P_MY, 16, 4, 4);
    push_seg(P_R1, 4, 1, 4);
    push_seg(P_SG, 80, 20, 4);
    push_seg(P_SY, 16, 4, 4);
    push_seg(P_R2, 4, 1, 4);
    push_seg(P_MG, 40, 96, 4);
    run("t6", 544);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
